// File: rtl/tsense_seq_ctrl.sv
// Conversion sequencer for the temperature-sense front-end: resets the core,
// waits for it to settle, then counts comparator-high samples over a
// 2^OSR_W-cycle window and publishes the count through a valid/ready register.
module tsense_seq_ctrl #(
   parameter int unsigned OSR_W      = 8,
   parameter int unsigned SETTLE_CYC = 16,
   parameter int unsigned INTERVAL_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  start,
   input  logic [INTERVAL_W-1:0] interval,
   input  logic                  cmp,
   output logic                  core_rst,
   output logic                  core_en,
   output logic                  busy,
   output logic [OSR_W:0]        res_data,
   output logic                  res_valid,
   input  logic                  res_ready,
   input  logic                  ovr_clr,
   output logic                  overrun
);

   localparam int unsigned ACC_W = OSR_W + 1;
   localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
   localparam int unsigned CNT_W = (ACC_W > SET_W) ? ACC_W : SET_W;

   // Terminal values of the shared phase counter (counts from 0)
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'((1 << OSR_W) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_SETTLE,
      S_CONV,
      S_WAIT
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        phase_cnt;
   logic [CNT_W-1:0]        phase_nxt;
   logic [INTERVAL_W-1:0]   wait_cnt;
   logic [ACC_W-1:0]        acc;
   logic [ACC_W-1:0]        acc_sum;
   logic                    conv_done_c;

   // Running count including the current cmp sample
   assign acc_sum = acc + ACC_W'(cmp);

   // Core control is a direct decode of the state register
   assign core_rst = (state == S_IDLE) || (state == S_RST);
   assign core_en  = (state == S_SETTLE) || (state == S_CONV) || (state == S_WAIT);
   assign busy     = (state != S_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; dropping en aborts any activity without a result
   always_comb begin
      state_nxt   = state;
      conv_done_c = 1'b0;
      phase_nxt   = '0;
      case (state)
         S_IDLE: begin
            if (en && start) state_nxt = S_RST;
         end
         S_RST: begin
            if (phase_cnt == RST_LAST) state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (phase_cnt == SETTLE_LAST) state_nxt = S_CONV;
         end
         S_CONV: begin
            if (phase_cnt == CONV_LAST) begin
               conv_done_c = 1'b1;
               state_nxt   = (interval == '0) ? S_IDLE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt == '0) state_nxt = S_RST;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (state != S_IDLE && !en) begin
         state_nxt   = S_IDLE;
         conv_done_c = 1'b0;
      end

      // Phase counter runs only while a timed state persists
      if (state_nxt == state &&
          (state == S_RST || state == S_SETTLE || state == S_CONV)) begin
         phase_nxt = phase_cnt + CNT_W'(1);
      end
   end

   // Phase, wait and accumulator counters
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_cnt <= '0;
         wait_cnt  <= '0;
         acc       <= '0;
      end else begin
         phase_cnt <= phase_nxt;
         if (conv_done_c) begin
            wait_cnt <= interval - INTERVAL_W'(1);
         end else if (state == S_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - INTERVAL_W'(1);
         end
         if (state == S_CONV && en && !conv_done_c) begin
            acc <= acc_sum;
         end else begin
            acc <= '0;
         end
      end
   end

   // Result register with valid/ready handshake and sticky overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         res_data  <= '0;
         res_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (conv_done_c) begin
            res_data  <= acc_sum;
            res_valid <= 1'b1;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end

         if (conv_done_c && res_valid && !res_ready) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tsense_seq_ctrl.sv
// Directed bench for tsense_seq_ctrl: table of single-shot conversions plus
// hand-written abort, start-pulse, periodic/overrun and reset sequences.
module tb_tsense_seq_ctrl;

   localparam int unsigned OSR_W      = 8;
   localparam int unsigned SETTLE_CYC = 16;
   localparam int unsigned INTERVAL_W = 16;
   localparam int          LAT        = 2 + SETTLE_CYC + (1 << OSR_W);
   localparam int          PERIOD     = LAT + 10;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  en = 1'b0;
   logic                  start = 1'b0;
   logic [INTERVAL_W-1:0] interval = '0;
   logic                  cmp = 1'b0;
   logic                  core_rst;
   logic                  core_en;
   logic                  busy;
   logic [OSR_W:0]        res_data;
   logic                  res_valid;
   logic                  res_ready = 1'b0;
   logic                  ovr_clr = 1'b0;
   logic                  overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int pat     = 2;

   typedef struct {
      string name;
      int    pat;
      int    exp_data;
      int    exp_lat;
   } vec_t;

   vec_t vecs[4];

   tsense_seq_ctrl #(
      .OSR_W(OSR_W),
      .SETTLE_CYC(SETTLE_CYC),
      .INTERVAL_W(INTERVAL_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .start(start),
      .interval(interval),
      .cmp(cmp),
      .core_rst(core_rst),
      .core_en(core_en),
      .busy(busy),
      .res_data(res_data),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .ovr_clr(ovr_clr),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // cmp stimulus patterns: 0 const high, 1 alternating, 2 const low, 3 every 4th
   function automatic logic cmp_fn(int p, int c);
      case (p)
         0:       return 1'b1;
         1:       return c[0];
         3:       return (c % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      cmp = cmp_fn(pat, cyc);
   endtask

   task automatic tick_n(int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic chk(string name, int act, int exp);
      n_tests = n_tests + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One single-shot conversion; checks reset release, latency, data, return to IDLE
   task automatic run_single(vec_t v);
      int first_low;
      int got;
      pat       = v.pat;
      interval  = '0;
      res_ready = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk({v.name, "_busy_start"}, int'(busy), 1);
      chk({v.name, "_rst_start"}, int'(core_rst), 1);
      first_low = 0;
      got       = 0;
      for (int n = 1; n <= 400 && got == 0; n++) begin
         tick();
         if (!core_rst && first_low == 0) begin
            first_low = n;
            chk({v.name, "_en_settle"}, int'(core_en), 1);
         end
         if (res_valid) got = n;
      end
      chk({v.name, "_rst_release"}, first_low, 2);
      chk({v.name, "_latency"}, got, v.exp_lat);
      chk({v.name, "_data"}, int'(res_data), v.exp_data);
      chk({v.name, "_busy_end"}, int'(busy), 0);
      chk({v.name, "_core_en_end"}, int'(core_en), 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({v.name, "_valid_clr"}, int'(res_valid), 0);
   endtask

   initial begin
      int got;
      int nres;

      vecs[0] = '{"cmp_hi",   0, 256, LAT};
      vecs[1] = '{"cmp_alt",  1, 128, LAT};
      vecs[2] = '{"cmp_lo",   2, 0,   LAT};
      vecs[3] = '{"cmp_q4",   3, 64,  LAT};

      // Reset state
      tick_n(3);
      reset = 1'b0;
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_data", int'(res_data), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_core_rst", int'(core_rst), 1);
      chk("rst_core_en", int'(core_en), 0);
      chk("rst_busy", int'(busy), 0);

      // start ignored while disabled
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_no_en", int'(busy), 0);
      en = 1'b1;

      // Table of single-shot conversions
      foreach (vecs[i]) run_single(vecs[i]);

      // en dropped after 100 CONV cycles aborts with no result
      pat   = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick_n(2 + SETTLE_CYC + 100);
      chk("abort_in_conv", int'(core_en), 1);
      en = 1'b0;
      tick();
      chk("abort_core_rst", int'(core_rst), 1);
      chk("abort_core_en", int'(core_en), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(res_valid), 0);
      en = 1'b1;
      tick_n(300);
      chk("abort_no_result", int'(res_valid), 0);
      run_single(vecs[0]);

      // Repeated start pulses during a conversion give exactly one result
      pat       = 1;
      res_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      nres  = 0;
      for (int n = 1; n <= 600; n++) begin
         start = (n < 270) && (n % 7 == 0);
         tick();
         if (res_valid) begin
            nres = nres + 1;
            if (nres == 1) begin
               chk("pulse_latency", n, LAT);
               chk("pulse_data", int'(res_data), 128);
            end
         end
      end
      start = 1'b0;
      chk("pulse_count", nres, 1);
      chk("pulse_busy", int'(busy), 0);
      res_ready = 1'b0;

      // Periodic mode, interval 10, consumer stalled
      pat      = 2;
      interval = INTERVAL_W'(10);
      start    = 1'b1;
      tick();
      start = 1'b0;
      got   = 0;
      for (int n = 1; n <= 400 && got == 0; n++) begin
         tick();
         if (res_valid) got = n;
      end
      chk("per1_latency", got, LAT);
      chk("per1_data", int'(res_data), 0);
      chk("per1_busy", int'(busy), 1);

      // Second result overwrites unread first: overrun
      pat = 0;
      tick_n(PERIOD - 1);
      chk("per2_early", int'(res_data), 0);
      tick();
      chk("per2_data", int'(res_data), 256);
      chk("per2_valid", int'(res_valid), 1);
      chk("per2_overrun", int'(overrun), 1);

      // Interval changed mid-WAIT has no effect; set beats clear on third result
      pat      = 1;
      interval = INTERVAL_W'(50);
      tick_n(PERIOD - 1);
      interval = INTERVAL_W'(10);
      chk("per3_early", int'(res_data), 256);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("per3_data", int'(res_data), 128);
      chk("per3_valid", int'(res_valid), 1);
      chk("per3_set_wins", int'(overrun), 1);

      // Clear overrun, then new result on same edge as a transfer
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_cleared", int'(overrun), 0);
      pat = 3;
      tick_n(PERIOD - 2);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("per4_data", int'(res_data), 64);
      chk("per4_valid", int'(res_valid), 1);
      chk("per4_no_ovr", int'(overrun), 0);

      // Fifth result unread: overrun again
      pat = 0;
      tick_n(PERIOD);
      chk("per5_data", int'(res_data), 256);
      chk("per5_overrun", int'(overrun), 1);

      // reset while in WAIT with valid and overrun set
      tick_n(3);
      chk("wait_core_en", int'(core_en), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", int'(res_valid), 0);
      chk("mid_rst_data", int'(res_data), 0);
      chk("mid_rst_overrun", int'(overrun), 0);
      chk("mid_rst_core_rst", int'(core_rst), 1);
      chk("mid_rst_core_en", int'(core_en), 0);
      chk("mid_rst_busy", int'(busy), 0);
      tick_n(400);
      chk("no_resume_busy", int'(busy), 0);
      chk("no_resume_valid", int'(res_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
